// File: rtl/i4001_rom.sv
// i4001-style program ROM on the MCS-4 4-bit multiplexed bus.
// Tracks the eight bus subcycles from sync, returns the addressed opcode
// nibbles in M1/M2 when this chip is selected, and provides one 4-bit I/O
// port addressed by SRC and accessed with WRR/RDR. The host loads the
// 256x8 array through a write-only programming port.
module i4001_rom #(
  parameter logic [3:0] CHIP_ID  = 4'h0,
  parameter logic [3:0] IO_RESET = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync,
  input  logic       cm_rom,
  input  logic [3:0] dbus_in,
  output logic [3:0] dbus_out,
  output logic       dbus_oe,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  input  logic       prog_we,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic       locked
);

  typedef enum logic [2:0] {
    PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3
  } phase_t;

  // Where the bus nibble comes from: the output register, or one half of
  // the registered ROM word (avoids a second, unregistered array read).
  typedef enum logic [1:0] {
    SRC_REG, SRC_OPR, SRC_OPA
  } out_src_t;

  localparam logic [3:0] OP_IO  = 4'hE;
  localparam logic [3:0] OP_WRR = 4'h2;
  localparam logic [3:0] OP_RDR = 4'hA;

  logic [7:0] rom [256];
  logic [7:0] rd;
  logic       rd_en;

  phase_t     phase;
  out_src_t   out_src;
  logic [3:0] addr_lo;
  logic [3:0] addr_hi;
  logic [3:0] opr_buf;
  logic [3:0] out_reg;
  logic [3:0] io_op;
  logic       io_op_valid;
  logic       rom_sel;
  logic       io_sel;
  logic       chip_match;

  assign rd_en      = locked && (phase == PH_A3);
  assign chip_match = (dbus_in == CHIP_ID);

  // Host writes and fetch reads share the array; a same-edge read sees old data.
  always_ff @(posedge clk) begin
    if (prog_we) rom[prog_addr] <= prog_data;
    if (rd_en)   rd <= rom[{addr_hi, addr_lo}];
  end

  // Phase tracking, address capture, bus drive and I/O port control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase       <= PH_X3;
      locked      <= 1'b0;
      dbus_oe     <= 1'b0;
      out_reg     <= 4'h0;
      out_src     <= SRC_REG;
      io_out      <= IO_RESET;
      addr_lo     <= 4'h0;
      addr_hi     <= 4'h0;
      opr_buf     <= 4'h0;
      io_op       <= 4'h0;
      io_op_valid <= 1'b0;
      rom_sel     <= 1'b0;
      io_sel      <= 1'b0;
    end else begin
      if (sync) begin
        phase  <= PH_A1;
        locked <= 1'b1;
      end else if (locked) begin
        phase <= phase_t'(phase + 3'd1);
      end

      if (locked) begin
        case (phase)
          PH_A1: addr_lo <= dbus_in;
          PH_A2: addr_hi <= dbus_in;
          PH_A3: begin
            rom_sel <= cm_rom && chip_match;
            if (cm_rom && chip_match) begin
              dbus_oe <= 1'b1;
              out_src <= SRC_OPR;
            end
          end
          PH_M1: begin
            if (rom_sel) out_src <= SRC_OPA;
            opr_buf <= dbus_in;
          end
          PH_M2: begin
            dbus_oe <= 1'b0;
            out_src <= SRC_REG;
            if (cm_rom && (opr_buf == OP_IO)) begin
              io_op       <= dbus_in;
              io_op_valid <= 1'b1;
            end else begin
              io_op_valid <= 1'b0;
            end
          end
          PH_X1: begin
            if (io_op_valid && (io_op == OP_RDR) && io_sel) begin
              out_reg <= io_in;
              dbus_oe <= 1'b1;
            end
          end
          PH_X2: begin
            dbus_oe <= 1'b0;
            if (cm_rom && !io_op_valid) io_sel <= chip_match;
            if (io_op_valid && (io_op == OP_WRR) && io_sel) io_out <= dbus_in;
          end
          PH_X3: begin
            if (!sync) begin
              locked  <= 1'b0;
              dbus_oe <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Select the bus nibble from the output register or the fetched word.
  always_comb begin
    dbus_out = out_reg;
    case (out_src)
      SRC_OPR: dbus_out = rd[7:4];
      SRC_OPA: dbus_out = rd[3:0];
      default: dbus_out = out_reg;
    endcase
  end

endmodule

// File: tb/tb_i4001_rom.sv
// Directed bench for i4001_rom: fetch, chip select, SRC/WRR/RDR, lock loss
// and mid-cycle reset, with a CPU-side bus model resolving the shared bus.
module tb_i4001_rom;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sync;
  logic       cm_rom;
  logic [3:0] dbus_in;
  logic [3:0] dbus_out;
  logic       dbus_oe;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;
  logic       locked;

  logic [3:0] cpu_d;
  int         tests = 0;
  int         fails = 0;

  logic       cur_oe, cur_lk;
  logic [3:0] cur_out, cur_io;
  logic [7:0] oe_vec, lk_vec;
  logic [3:0] out_obs [8];
  logic [3:0] io_obs [8];

  always #5 clk = ~clk;

  assign dbus_in = dbus_oe ? dbus_out : cpu_d;

  i4001_rom #(.CHIP_ID(4'h0), .IO_RESET(4'h7)) dut (
    .clk(clk), .rst_n(rst_n), .sync(sync), .cm_rom(cm_rom),
    .dbus_in(dbus_in), .dbus_out(dbus_out), .dbus_oe(dbus_oe),
    .io_in(io_in), .io_out(io_out), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .locked(locked)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One subcycle: drive CPU side, sample the DUT, then take the edge.
  task automatic step(input logic [3:0] d, input logic cm, input logic s);
    cpu_d  = d;
    cm_rom = cm;
    sync   = s;
    #1;
    cur_oe  = dbus_oe;
    cur_out = dbus_out;
    cur_io  = io_out;
    cur_lk  = locked;
    @(posedge clk);
    #1;
  endtask

  // A full A1..X3 instruction cycle; pw3 writes rom[3C]=5A on the A3 edge.
  task automatic bus_cycle(input logic [3:0] a1, a2, a3, input logic cm3,
                           input logic [3:0] m1, m2, input logic cm2,
                           input logic [3:0] x2, input logic cmx2,
                           input logic [3:0] ioi, input logic sync_end,
                           input logic pw3);
    logic [3:0] d;
    logic       cm;
    io_in = ioi;
    for (int p = 0; p < 8; p++) begin
      case (p)
        0: begin d = a1; cm = 1'b0; end
        1: begin d = a2; cm = 1'b0; end
        2: begin d = a3; cm = cm3;  end
        3: begin d = m1; cm = 1'b0; end
        4: begin d = m2; cm = cm2;  end
        6: begin d = x2; cm = cmx2; end
        default: begin d = 4'h0; cm = 1'b0; end
      endcase
      if (p == 2 && pw3) begin
        prog_addr = 8'h3C;
        prog_data = 8'h5A;
        prog_we   = 1'b1;
      end else begin
        prog_we = 1'b0;
      end
      step(d, cm, (p == 7) ? sync_end : 1'b0);
      oe_vec[p]  = cur_oe;
      lk_vec[p]  = cur_lk;
      out_obs[p] = cur_out;
      io_obs[p]  = cur_io;
    end
    prog_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sync = 1'b0; cm_rom = 1'b0; cpu_d = 4'h0; io_in = 4'h0;
    prog_we = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;
    oe_vec = 8'h00; lk_vec = 8'h00;

    // Program during reset: writes are independent of reset.
    @(posedge clk); #1;
    prog_we = 1'b1; prog_addr = 8'h3C; prog_data = 8'hA5;
    @(posedge clk); #1;
    prog_we = 1'b0;
    @(posedge clk); #1;
    chk("reset_oe", {7'd0, dbus_oe}, 8'h00);
    chk("reset_out", {4'd0, dbus_out}, 8'h00);
    chk("reset_io_out", {4'd0, io_out}, 8'h07);
    chk("reset_locked", {7'd0, locked}, 8'h00);
    rst_n = 1'b1;

    // Lock onto the bus.
    step(4'h0, 1'b0, 1'b1);
    chk("lock_after_sync", {7'd0, locked}, 8'h01);

    // 1: selected fetch of 3C -> A in M1, 5 in M2.
    bus_cycle(4'hC, 4'h3, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("fetch_oe_window", oe_vec, 8'b0001_1000);
    chk("fetch_opr", {4'd0, out_obs[3]}, 8'h0A);
    chk("fetch_opa", {4'd0, out_obs[4]}, 8'h05);
    chk("fetch_locked", lk_vec, 8'hFF);

    // 2: other chip number -> no drive, io_out untouched.
    bus_cycle(4'hC, 4'h3, 4'h1, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("desel_oe", oe_vec, 8'h00);
    chk("desel_io_out", {4'd0, io_obs[7]}, 8'h07);

    // 3: SRC to chip 0, then WRR 9.
    bus_cycle(4'h0, 4'h0, 4'h1, 1'b1, 4'h2, 4'h1, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0);
    chk("src_oe", oe_vec, 8'h00);
    bus_cycle(4'h1, 4'h0, 4'h1, 1'b1, 4'hE, 4'h2, 1'b1, 4'h9, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("wrr_io_before", {4'd0, io_obs[6]}, 8'h07);
    chk("wrr_io_after", {4'd0, io_obs[7]}, 8'h09);
    chk("wrr_oe", oe_vec, 8'h00);

    // 4: RDR with io_in=6 drives only during X2.
    bus_cycle(4'h2, 4'h0, 4'h1, 1'b1, 4'hE, 4'hA, 1'b1, 4'h0, 1'b0, 4'h6, 1'b1, 1'b0);
    chk("rdr_oe_window", oe_vec, 8'b0100_0000);
    chk("rdr_data", {4'd0, out_obs[6]}, 8'h06);
    // SRC to chip 3: RDR silent, WRR ignored.
    bus_cycle(4'h0, 4'h0, 4'h1, 1'b1, 4'h2, 4'h1, 1'b0, 4'h3, 1'b1, 4'h0, 1'b1, 1'b0);
    bus_cycle(4'h2, 4'h0, 4'h1, 1'b1, 4'hE, 4'hA, 1'b1, 4'h0, 1'b0, 4'h6, 1'b1, 1'b0);
    chk("rdr_unsel_oe", oe_vec, 8'h00);
    bus_cycle(4'h1, 4'h0, 4'h1, 1'b1, 4'hE, 4'h2, 1'b1, 4'h4, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("wrr_unsel_io", {4'd0, io_obs[7]}, 8'h09);

    // 5: missing sync drops lock; next cycle idle; then relock and fetch.
    bus_cycle(4'h0, 4'h0, 4'h1, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("nosync_locked_in_cycle", lk_vec, 8'hFF);
    bus_cycle(4'hC, 4'h3, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("unlocked_locked", lk_vec, 8'h00);
    chk("unlocked_oe", oe_vec, 8'h00);
    chk("relock", {7'd0, locked}, 8'h01);
    bus_cycle(4'hC, 4'h3, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("relock_oe", oe_vec, 8'b0001_1000);
    chk("relock_opr", {4'd0, out_obs[3]}, 8'h0A);
    chk("relock_opa", {4'd0, out_obs[4]}, 8'h05);

    // Same-edge write and read: old data now, new data on refetch.
    bus_cycle(4'hC, 4'h3, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1);
    chk("wr_rd_old_opr", {4'd0, out_obs[3]}, 8'h0A);
    chk("wr_rd_old_opa", {4'd0, out_obs[4]}, 8'h05);
    bus_cycle(4'hC, 4'h3, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("new_opr", {4'd0, out_obs[3]}, 8'h05);
    chk("new_opa", {4'd0, out_obs[4]}, 8'h0A);

    // 6: reset asserted during M1 of a selected fetch.
    step(4'hC, 1'b0, 1'b0);
    step(4'h3, 1'b0, 1'b0);
    step(4'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    step(4'h0, 1'b0, 1'b0);
    chk("m1_driving_before_reset", {7'd0, cur_oe}, 8'h01);
    chk("rst_mid_oe", {7'd0, dbus_oe}, 8'h00);
    chk("rst_mid_io_out", {4'd0, io_out}, 8'h07);
    chk("rst_mid_locked", {7'd0, locked}, 8'h00);
    rst_n = 1'b1;
    step(4'h0, 1'b0, 1'b1);
    bus_cycle(4'hC, 4'h3, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("post_rst_opr", {4'd0, out_obs[3]}, 8'h05);
    chk("post_rst_opa", {4'd0, out_obs[4]}, 8'h0A);
    chk("post_rst_oe", oe_vec, 8'b0001_1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i4001_rom.md
Name: i4001_rom

Overview:
MCS-4 program ROM, modelled on the i4001. It sits on the 4-bit multiplexed bus downstream of the i4004 core: it captures the 8-bit fetch address in A1/A2, and the chip number in A3. When selected, it returns the opcode nibbles (OPR in M1, OPA in M2). It also provides one 4-bit I/O port, selected by SRC and driven by WRR/RDR. Contents are loaded by the PYNQ host through a write-only programming port.

Parameters:
CHIP_ID, 4'h0, chip number compared against the A3 nibble and the SRC high nibble
IO_RESET, 4'h0, io_out value after reset

Ports:
clk  in  1  system clock; one bus subcycle per clk
rst_n  in  1  synchronous reset, active-low
sync  in  1  from CPU; high during X3; the next cycle is A1
cm_rom  in  1  CPU ROM command line
dbus_in  in  4  resolved shared data bus, including this block's own drive
dbus_out  out  4  nibble driven onto the bus
dbus_oe  out  1  dbus_out valid and owned by this chip
io_in  in  4  I/O port input pins
io_out  out  4  I/O port output latch
prog_we  in  1  host write strobe
prog_addr  in  8  host write address
prog_data  in  8  host write data: [7:4]=OPR, [3:0]=OPA
locked  out  1  phase tracker synchronised to sync

Behaviour:
Reset (rst_n=0 at posedge):
- dbus_out=0, dbus_oe=0, io_out=IO_RESET, locked=0.
- Internal flags cleared: rom_sel=0, io_sel=0, io_op=NONE.
- ROM array is not reset.
- Reset applied mid-cycle drops dbus_oe at that edge.

Phase tracker: 3-bit phase A1,A2,A3,M1,M2,X1,X2,X3.
- Posedge with sync=1: phase<=A1, locked<=1. This takes priority at any phase.
- Otherwise, if locked: phase<=phase+1.
- At phase X3 with sync=0: locked<=0, dbus_oe<=0. The tracker stays idle until the next sync.
- While locked=0: no capture and no drive.

Fetch, at each edge that ends the named phase:
- A1: addr_lo<=dbus_in.
- A2: addr_hi<=dbus_in.
- A3:
  - rom_sel<=(cm_rom && dbus_in==CHIP_ID).
  - rd<=rom[{addr_hi,addr_lo}].
  - If selected: dbus_out<=rd[7:4], dbus_oe<=1.
- M1: if rom_sel: dbus_out<=rd[3:0], dbus_oe stays 1. Also opr_buf<=dbus_in.
- M2:
  - dbus_oe<=0.
  - If cm_rom && opr_buf==4'hE: io_op<=dbus_in; otherwise io_op<=NONE.
- Net effect: dbus_oe is high exactly during M1 and M2 of a selected cycle. Read latency from A3 is one clk.

SRC and I/O:
- X2 edge with cm_rom=1 and io_op==NONE (SRC): io_sel<=(dbus_in==CHIP_ID).
- X1 edge with io_op==4'hA (RDR) && io_sel: dbus_out<=io_in, dbus_oe<=1, held for X2.
- X2 edge:
  - dbus_oe<=0.
  - If io_op==4'h2 (WRR) && io_sel: io_out<=dbus_in. The new value is visible from X3.
- io_sel persists until the next SRC or reset.
- Other 4'hE sub-ops are ignored.

Programming port:
- rom[prog_addr]<=prog_data on any edge with prog_we=1, regardless of locked or reset.
- A write and a fetch read to the same address in one edge: the read returns the old data.

Address wrap: the 8-bit address only; page and chip selection belong to the CPU.

Test Plan:
1. Program rom[8'h3C]=8'hA5, CHIP_ID=0. Issue sync, then A1=C, A2=3, A3=0 with cm_rom=1. Expect dbus_out=A in M1 and 5 in M2, dbus_oe high exactly 2 cycles.
2. Same cycle with A3 nibble=1. Expect dbus_oe=0 for the whole cycle and io_out unchanged.
3. SRC (cm_rom=1 in X2, dbus_in=0), then next instruction M1=E, M2=2 with cm_rom=1, X2 dbus_in=9. Expect io_out=9 from X3 onward.
4. After SRC to chip 0, RDR (E,A) with io_in=6. Expect dbus_oe=1 and dbus_out=6 during X2 only. Repeat after SRC to chip 3: no drive.
5. Omit sync at one X3. Expect locked=0 and no drive next cycle. Reassert sync: relock and a correct fetch on the following cycle.
6. Assert rst_n=0 during M1 of a selected fetch. Expect dbus_oe=0 and io_out=IO_RESET after that edge, locked=0, and ROM contents preserved on refetch.
